// File: rtl/cv32e40x_pkg.sv
// Shared types for the OBI instruction/data arbiter.
package cv32e40x_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } obi_arb_state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } obi_arb_src_e;

  localparam int unsigned OBI_ARB_CNT_W = 4;

endpackage

// File: rtl/cv32e40x_obi_arb_fifo.sv
// Routing FIFO: remembers which requester owns each outstanding transfer.
module cv32e40x_obi_arb_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     data_i,
  input  logic                     pop_i,
  output logic                     data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [OBI_ARB_CNT_W-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]         mem_q, mem_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OBI_ARB_CNT_W-1:0] count_q, count_d;
  logic                     pop_ok, push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == OBI_ARB_CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot first, so a push into a full FIFO is legal alongside it.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OBI_ARB_CNT_W'(1);
      2'b01:   count_d = count_q - OBI_ARB_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cv32e40x_obi_arbiter.sv
// Two-master (instruction/data) to one-slave OBI arbiter with in-order response routing.
// Define CV32E40X_OBI_ARB_ROUND_ROBIN_EN for round-robin instead of data-first priority.
//
// state  | meaning
// ARB    | free to pick a requester each cycle (when not full)
// LOCKED | request presented but not granted; source held until m_gnt_i
module cv32e40x_obi_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  input  logic [3:0]  i_be_i,
  input  logic [31:0] i_wdata_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  input  logic        m_err_i,
  output logic [3:0]  outstanding_o
);

  obi_arb_state_e state_q, state_d;
  obi_arb_src_e   src_q, src_d;
  obi_arb_src_e   sel_src, pref_src, head_src;
  logic           sel_valid;
  logic           push, pop;
  logic           fifo_head, fifo_empty, fifo_full;

`ifdef CV32E40X_OBI_ARB_ROUND_ROBIN_EN
  obi_arb_src_e rr_q, rr_d;

  // rr_q holds the last granted source; the other one wins a tie.
  assign pref_src = (rr_q == SRC_D) ? SRC_I : SRC_D;
  assign rr_d     = push ? sel_src : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= SRC_I;
    else        rr_q <= rr_d;
  end
`else
  assign pref_src = SRC_D;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    sel_valid = 1'b0;
    sel_src   = SRC_D;
    case (state_q)
      ARB: begin
        if (!fifo_full) begin
          if (d_req_i && i_req_i) sel_src = pref_src;
          else                    sel_src = d_req_i ? SRC_D : SRC_I;
          sel_valid = d_req_i | i_req_i;
        end
        if (sel_valid && !m_gnt_i) begin
          state_d = LOCKED;
          src_d   = sel_src;
        end
      end
      LOCKED: begin
        sel_valid = 1'b1;
        sel_src   = src_q;
        if (m_gnt_i) state_d = ARB;
      end
    endcase
    // Outputs must be quiet while reset is asserted, even with requests pending.
    if (!rst_n) sel_valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      src_q   <= SRC_I;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  assign m_req_o = sel_valid;
  assign push    = sel_valid & m_gnt_i;
  assign i_gnt_o = push & (sel_src == SRC_I);
  assign d_gnt_o = push & (sel_src == SRC_D);

  always_comb begin
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    if (sel_valid) begin
      if (sel_src == SRC_D) begin
        m_addr_o  = d_addr_i;
        m_we_o    = d_we_i;
        m_be_o    = d_be_i;
        m_wdata_o = d_wdata_i;
      end else begin
        m_addr_o  = i_addr_i;
        m_we_o    = i_we_i;
        m_be_o    = i_be_i;
        m_wdata_o = i_wdata_i;
      end
    end
  end

  // Responses with nothing outstanding are stray and dropped.
  assign pop      = m_rvalid_i & ~fifo_empty;
  assign head_src = obi_arb_src_e'(fifo_head);

  assign i_rvalid_o = pop & (head_src == SRC_I);
  assign d_rvalid_o = pop & (head_src == SRC_D);
  assign i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;
  assign i_err_o    = i_rvalid_o & m_err_i;
  assign d_err_o    = d_rvalid_o & m_err_i;

  cv32e40x_obi_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (sel_src),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (outstanding_o)
  );

endmodule
